// File: rtl/route_stage_sequencer.sv
// Walks a packet through NSTAGE pipeline stages one at a time, handing the
// shared memory port to whichever stage is currently active.
module route_stage_sequencer #(
  parameter int NSTAGE  = 8,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clock,
  input  logic                     nrst,
  input  logic                     en,
  input  logic                     isAggregated,
  input  logic [NSTAGE-1:0]        stage_done,
  input  logic [NSTAGE-1:0]        stage_exit,
  input  logic [NSTAGE*ADDR_W-1:0] stage_addr,
  input  logic [NSTAGE-1:0]        stage_wren,
  input  logic [NSTAGE*DATA_W-1:0] stage_wdata,
  output logic [NSTAGE-1:0]        stage_start,
  output logic [ADDR_W-1:0]        address,
  output logic                     wr_en,
  output logic [DATA_W-1:0]        mem_data_in,
  output logic [2:0]               active_stage,
  output logic                     busy,
  output logic                     done,
  output logic                     forAggregation,
  output logic                     timeout_err
);

  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(TIMEOUT);
  localparam logic [2:0]      LAST_STAGE = 3'(NSTAGE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_ABORT  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [2:0]      activeStage_q, activeStage_d;
  logic [WD_W-1:0] watchdog_q, watchdog_d;
  logic            forAgg_q, forAgg_d;
  logic            timeoutErr_q, timeoutErr_d;

  logic [ADDR_W-1:0] stageAddrArr  [NSTAGE];
  logic [DATA_W-1:0] stageWdataArr [NSTAGE];

  for (genvar g = 0; g < NSTAGE; g++) begin : gUnpack
    assign stageAddrArr[g]  = stage_addr[g*ADDR_W +: ADDR_W];
    assign stageWdataArr[g] = stage_wdata[g*DATA_W +: DATA_W];
  end

  logic            stageHit;
  logic            stageExitHit;
  logic            portOwned;
  logic [WD_W-1:0] watchdogInc;
  logic            watchdogExpired;

  assign stageHit     = stage_done[activeStage_q];
  assign stageExitHit = stage_exit[activeStage_q];
  assign portOwned    = (state_q == S_START) || (state_q == S_RUN);

  // Saturating so a stalled stage can never wrap back below the limit.
  assign watchdogInc     = (watchdog_q == WD_LIMIT) ? watchdog_q : watchdog_q + 1'b1;
  assign watchdogExpired = (watchdogInc == WD_LIMIT);

  always_comb begin
    state_d       = state_q;
    activeStage_d = activeStage_q;
    watchdog_d    = watchdog_q;
    forAgg_d      = forAgg_q;
    timeoutErr_d  = timeoutErr_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d       = S_START;
          activeStage_d = 3'd0;
          forAgg_d      = 1'b0;
          timeoutErr_d  = 1'b0;
        end
      end
      S_START: begin
        watchdog_d = '0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        watchdog_d = watchdogInc;
        // A completing stage takes priority over a watchdog expiring on the same cycle.
        if (stageHit) begin
          if (stageExitHit) begin
            state_d  = S_FINISH;
            forAgg_d = 1'b1;
          end else if ((activeStage_q == 3'd0) && isAggregated) begin
            state_d  = S_FINISH;
            forAgg_d = 1'b0;
          end else if (activeStage_q == LAST_STAGE) begin
            state_d = S_FINISH;
          end else begin
            state_d       = S_START;
            activeStage_d = activeStage_q + 3'd1;
          end
        end else if (watchdogExpired) begin
          state_d      = S_ABORT;
          timeoutErr_d = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      activeStage_q <= 3'd0;
      watchdog_q    <= '0;
      forAgg_q      <= 1'b0;
      timeoutErr_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      activeStage_q <= activeStage_d;
      watchdog_q    <= watchdog_d;
      forAgg_q      <= forAgg_d;
      timeoutErr_q  <= timeoutErr_d;
    end
  end

  always_comb begin
    stage_start = '0;
    if (state_q == S_START) stage_start[activeStage_q] = 1'b1;
  end

  always_comb begin
    address     = '0;
    wr_en       = 1'b0;
    mem_data_in = '0;
    if (portOwned) begin
      address     = stageAddrArr[activeStage_q];
      wr_en       = stage_wren[activeStage_q];
      mem_data_in = stageWdataArr[activeStage_q];
    end
  end

  assign active_stage   = activeStage_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FINISH) || (state_q == S_ABORT);
  assign forAggregation = forAgg_q;
  assign timeout_err    = timeoutErr_q;

endmodule

// File: tb/tb_route_stage_sequencer.sv
// Bench for route_stage_sequencer: a per-packet timeline model plans every
// output cycle from the stage delays, and a negedge process compares the DUT.
module tb_route_stage_sequencer;

  localparam int N    = 8;
  localparam int AW   = 11;
  localparam int DW   = 16;
  localparam int TOUT = 15;
  localparam int NCYC = 4096;

  logic            clock;
  logic            nrst;
  logic            en;
  logic            isAggregated;
  logic [N-1:0]    stage_done;
  logic [N-1:0]    stage_exit;
  logic [N*AW-1:0] stage_addr;
  logic [N-1:0]    stage_wren;
  logic [N*DW-1:0] stage_wdata;
  logic [N-1:0]    stage_start;
  logic [AW-1:0]   address;
  logic            wr_en;
  logic [DW-1:0]   mem_data_in;
  logic [2:0]      active_stage;
  logic            busy;
  logic            done;
  logic            forAggregation;
  logic            timeout_err;

  route_stage_sequencer #(
    .NSTAGE(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TOUT)
  ) dut (
    .clock(clock), .nrst(nrst), .en(en), .isAggregated(isAggregated),
    .stage_done(stage_done), .stage_exit(stage_exit), .stage_addr(stage_addr),
    .stage_wren(stage_wren), .stage_wdata(stage_wdata), .stage_start(stage_start),
    .address(address), .wr_en(wr_en), .mem_data_in(mem_data_in),
    .active_stage(active_stage), .busy(busy), .done(done),
    .forAggregation(forAggregation), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Stage behaviour: stage k raises done this many cycles after its start pulse;
  // anything beyond TOUT means the stage never finishes in time.
  int           doneDelay [N];
  logic [N-1:0] noiseMask;
  logic [N-1:0] one;

  bit expBusy [NCYC];
  bit expDone [NCYC];
  bit expAccept [NCYC];
  bit expSetAgg [NCYC];
  bit expSetErr [NCYC];
  bit expIdxZero [NCYC];
  int expStart [NCYC];
  int expOwner [NCYC];
  int driveDone [NCYC];

  int busyEnd   = -1;
  bit modelAgg  = 0;
  bit modelErr  = 0;
  bit modelLive = 0;

  int startOrder [$];
  int startCyc [$];
  int doneCyc [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clearFrom(input int c0);
    for (int c = c0; c < NCYC; c++) begin
      expBusy[c] = 0; expDone[c] = 0; expAccept[c] = 0; expSetAgg[c] = 0;
      expSetErr[c] = 0; expIdxZero[c] = 0;
      expStart[c] = -1; expOwner[c] = -1; driveDone[c] = -1;
    end
  endtask

  // Lays out a whole packet accepted at edge a: each stage owns the port from
  // its start cycle through its done cycle, then the next stage starts.
  task automatic planPacket(input int a);
    int s;
    int endCyc;
    s = a;
    endCyc = a;
    expAccept[a] = 1;
    for (int k = 0; k < N; k++) begin
      expStart[s] = k;
      if (doneDelay[k] > TOUT) begin
        for (int c = s; c <= s + TOUT; c++) expOwner[c] = k;
        endCyc = s + TOUT + 1;
        expSetErr[endCyc] = 1;
        break;
      end
      for (int c = s; c <= s + doneDelay[k]; c++) expOwner[c] = k;
      driveDone[s + doneDelay[k]] = k;
      endCyc = s + doneDelay[k] + 1;
      if (stage_exit[k]) begin
        expSetAgg[endCyc] = 1;
        break;
      end
      if ((k == 0 && isAggregated) || k == N - 1) break;
      s = endCyc;
    end
    expDone[endCyc] = 1;
    for (int c = a; c <= endCyc; c++) expBusy[c] = 1;
    busyEnd = endCyc;
  endtask

  initial clearFrom(0);

  // isAggregated and stage_exit are held steady for a whole packet, so reading
  // them at acceptance equals reading them when the deciding stage finishes.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (!nrst) begin
      clearFrom(cyc);
      busyEnd = cyc - 1;
      expIdxZero[cyc] = 1;
      modelAgg = 0;
      modelErr = 0;
      modelLive = 1;
    end else if (modelLive) begin
      if (en && (cyc - 1 > busyEnd)) planPacket(cyc);
      if (expAccept[cyc]) begin
        modelAgg = 0;
        modelErr = 0;
      end
      if (expSetAgg[cyc]) modelAgg = 1;
      if (expSetErr[cyc]) modelErr = 1;
    end
  end

  task automatic checkOutput();
    int c;
    int o;
    logic [N-1:0]  eStart;
    logic [AW-1:0] eAddr;
    logic          eWr;
    logic [DW-1:0] eData;
    c = cyc;
    o = expOwner[c];
    eStart = (expStart[c] >= 0) ? (one << expStart[c]) : '0;
    eAddr = '0; eWr = 1'b0; eData = '0;
    if (o >= 0) begin
      eAddr = stage_addr[o*AW +: AW];
      eWr   = stage_wren[o];
      eData = stage_wdata[o*DW +: DW];
      chk("active_stage", active_stage, o);
    end else if (expIdxZero[c]) begin
      chk("active_stage_rst", active_stage, 0);
    end
    chk("busy", busy, expBusy[c]);
    chk("done", done, expDone[c]);
    chk("stage_start", stage_start, eStart);
    chk("address", address, eAddr);
    chk("wr_en", wr_en, eWr);
    chk("mem_data_in", mem_data_in, eData);
    chk("forAggregation", forAggregation, modelAgg);
    chk("timeout_err", timeout_err, modelErr);
  endtask

  always @(negedge clock) begin
    stage_done = noiseMask;
    if (cyc < NCYC && driveDone[cyc] >= 0) stage_done = noiseMask | (one << driveDone[cyc]);
    if (modelLive && cyc < NCYC) begin
      checkOutput();
      for (int k = 0; k < N; k++) begin
        if (stage_start[k] === 1'b1) begin
          startOrder.push_back(k);
          startCyc.push_back(cyc);
        end
      end
      if (done === 1'b1) doneCyc.push_back(cyc);
    end
  end

  task automatic applyStimulus(input logic enVal, input logic nrstVal);
    @(negedge clock);
    en = enVal;
    nrst = nrstVal;
  endtask

  task automatic pulseEn(output int enCycle);
    applyStimulus(1'b1, 1'b1);
    enCycle = cyc;
    applyStimulus(1'b0, 1'b1);
  endtask

  task automatic waitIdle(input int limit, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy !== 1'b0 && n < limit);
    chk(name, busy, 0);
  endtask

  task automatic waitStage(input int k, input int limit, input string name);
    int n;
    n = 0;
    while (!(busy === 1'b1 && active_stage === 3'(k)) && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk(name, active_stage, k);
  endtask

  function automatic int firstOr(input int q [$]);
    return (q.size() > 0) ? q[0] : -1000;
  endfunction

  task automatic clearLogs();
    startOrder.delete();
    startCyc.delete();
    doneCyc.delete();
  endtask

  task automatic setDelays(input int d);
    for (int k = 0; k < N; k++) doneDelay[k] = d;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] stopping");
  end

  initial begin
    int t;
    int packed3;
    one = 1;
    nrst = 1'b0;
    en = 1'b1;
    isAggregated = 1'b0;
    stage_exit = '0;
    stage_done = '0;
    noiseMask = '0;
    stage_wren = 8'b1010_0110;
    for (int k = 0; k < N; k++) begin
      stage_addr[k*AW +: AW]  = 11'h100 + 11'(k * 11'h11);
      stage_wdata[k*DW +: DW] = 16'h1000 + 16'(k);
    end
    stage_addr[5*AW +: AW]  = 11'h668;
    stage_wdata[5*DW +: DW] = 16'h00A5;
    setDelays(1);

    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_start", stage_start, 0);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] latency pass, every stage done after one RUN cycle");
    clearLogs();
    pulseEn(t);
    waitIdle(100, "latency_idle");
    chk("latency_done_count", doneCyc.size(), 1);
    chk("latency_cycles", firstOr(doneCyc) - t, 17);

    $display("[TB] full pass, stages done 3 cycles after start, extra en while busy");
    setDelays(3);
    clearLogs();
    pulseEn(t);
    repeat (4) @(negedge clock);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    waitIdle(200, "full_idle");
    packed3 = 0;
    foreach (startOrder[i]) packed3 = (packed3 << 3) | startOrder[i];
    chk("full_start_count", startOrder.size(), 8);
    chk("full_start_order", packed3, 24'h053977);
    chk("full_done_count", doneCyc.size(), 1);
    chk("full_forAgg", forAggregation, 0);
    chk("full_terr", timeout_err, 0);

    $display("[TB] aggregated packet stops after stage 0");
    setDelays(2);
    isAggregated = 1'b1;
    clearLogs();
    pulseEn(t);
    waitIdle(100, "agg_idle");
    chk("agg_start_count", startOrder.size(), 1);
    chk("agg_done_gap", firstOr(doneCyc) - firstOr(startCyc), 3);
    chk("agg_forAgg", forAggregation, 0);
    isAggregated = 1'b0;

    $display("[TB] early exit at stage 3 with stray done on stages 6,7");
    setDelays(1);
    stage_exit = 8'b0000_1000;
    noiseMask = 8'b1100_0000;
    clearLogs();
    pulseEn(t);
    waitIdle(100, "exit_idle");
    chk("exit_start_count", startOrder.size(), 4);
    chk("exit_forAgg", forAggregation, 1);
    repeat (5) @(negedge clock);
    chk("exit_forAgg_held", forAggregation, 1);
    stage_exit = '0;
    noiseMask = '0;

    $display("[TB] memory port mux while stage 5 owns it");
    doneDelay[5] = 6;
    pulseEn(t);
    chk("mux_forAgg_cleared", forAggregation, 0);
    waitStage(5, 50, "mux_reach5");
    chk("mux_address", address, 11'h668);
    chk("mux_wr_en", wr_en, 1);
    chk("mux_data", mem_data_in, 16'h00A5);
    waitIdle(100, "mux_idle");
    chk("idle_address", address, 0);
    chk("idle_wr_en", wr_en, 0);
    chk("idle_data", mem_data_in, 0);

    $display("[TB] watchdog: stage 2 never completes");
    setDelays(1);
    doneDelay[2] = 1000;
    noiseMask = 8'b1111_1000;
    clearLogs();
    pulseEn(t);
    waitIdle(100, "wd_idle");
    chk("wd_abort_gap", firstOr(doneCyc) - ((startCyc.size() > 2) ? startCyc[2] : -1000), 16);
    chk("wd_terr_sticky", timeout_err, 1);
    noiseMask = '0;

    $display("[TB] reset mid-RUN at stage 4 with en held high");
    setDelays(3);
    pulseEn(t);
    chk("wd_terr_cleared", timeout_err, 0);
    waitStage(4, 100, "rst_reach4");
    applyStimulus(1'b1, 1'b0);
    @(negedge clock);
    chk("midrst_busy", busy, 0);
    chk("midrst_active", active_stage, 0);
    chk("midrst_start", stage_start, 0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    @(negedge clock);
    chk("restart_busy", busy, 1);
    chk("restart_stage0", stage_start, 8'h01);
    en = 1'b0;
    waitIdle(200, "restart_idle");

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
